mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencing controller that shares the single-ported unified memory between instruction fetch (IF) and data memory access (DM) in the pipelined RV32 core. It drives the select of the 32-bit address mux feeding the memory, runs a variable-latency valid/ready handshake to memory, and returns a one-cycle acknowledge with read data to the winning requester. DM has priority, with a starvation guard for IF and a timeout that aborts hung transactions.

## Interface
- STARVE_MAX, 4: consecutive DM grants made while if_req was pending, after which IF wins the next contested decision (≥1).
- TIMEOUT, 15: busy cycles without mem_ready before the transaction is aborted (≥1).

- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request, held until if_ack.
- if_ack  out  1  one-cycle fetch completion pulse.
- if_rdata  out  32  fetch data, valid while if_ack=1.
- dm_req  in  1  data request, held until dm_ack.
- dm_we  in  1  data write enable, sampled at grant.
- dm_ack  out  1  one-cycle data completion pulse.
- dm_rdata  out  32  load data, valid while dm_ack=1.
- addr_sel  out  1  address mux select: 0 = fetch address, 1 = data address.
- mem_valid  out  1  transaction active to memory.
- mem_we  out  1  write qualifier to memory.
- mem_ready  in  1  memory completion, one cycle.
- mem_rdata  in  32  memory read data, valid with mem_ready.
- bus_err  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, IF_BUSY, DM_BUSY.
- IDLE decision, using only requests not masked: a requester whose ack is 1 this cycle is masked.
  - If dm_req and (!if_req or starve_cnt < STARVE_MAX), go to DM_BUSY with addr_sel=1 and mem_we=dm_we.
  - Else if if_req, go to IF_BUSY with addr_sel=0 and mem_we=0.
  - Else stay in IDLE.
- starve_cnt, width $clog2(STARVE_MAX+1), updates only at a grant:
  - +1 (saturating at STARVE_MAX) on a DM grant with if_req=1.
  - Cleared on an IF grant, or on a DM grant with if_req=0.
- BUSY states:
  - mem_valid=1. addr_sel and mem_we are held constant for the whole transaction.
  - wait_cnt, width $clog2(TIMEOUT+1), counts busy cycles from 1.
- Completion: on mem_ready=1 in a BUSY state, on the next edge:
  - The matching ack goes to 1 and its rdata takes mem_rdata (rdata is also captured for writes).
  - State goes to IDLE, mem_valid=0, wait_cnt clears.
- Timeout: when wait_cnt reaches TIMEOUT with mem_ready=0, on the next edge:
  - The matching ack goes to 1 with rdata=32'h0, and bus_err=1.
  - State goes to IDLE and mem_valid=0.
  - If mem_ready=1 in the same cycle wait_cnt reaches TIMEOUT, normal completion wins and bus_err stays 0.
- mem_ready in IDLE is ignored; no ack is produced.
- addr_sel keeps its last value in IDLE.
- Requests dropped mid-transaction do not cancel it; the ack is still pulsed.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, addr_sel=0, mem_valid=0, mem_we=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0, bus_err=0, starve_cnt=0, wait_cnt=0.
- Reset mid-transaction: mem_valid=0 after the reset edge and no ack is issued. The requester must re-request.
- Latency: request seen at IDLE edge N gives mem_valid=1 at N+1. mem_ready at edge M gives ack=1 at M+1 and IDLE at M+1.
- Best-case turnaround is 3 cycles with zero-wait memory (mem_ready in the first busy cycle).
- The ack mask stops back-to-back re-grant of a requester that deasserts req in the cycle after its ack. The other requester can be granted in that ack cycle.
- Simultaneous if_req and dm_req in IDLE are resolved by the priority/starvation rule above; there is never a dual grant.

## Test plan
- Reset/idle: assert rst mid DM_BUSY (wait 2 cycles) → next cycle mem_valid=0, dm_ack never pulses, all outputs 0. Lone if_req with mem_ready one cycle after mem_valid and mem_rdata=32'h00500093 → if_ack one cycle later with if_rdata=32'h00500093, addr_sel=0.
- Priority: if_req and dm_req rise together with dm_we=1 → DM granted first (addr_sel=1, mem_we=1). IF granted immediately after dm_ack, with addr_sel=0 and mem_we=0.
- Starvation: hold if_req=1 and re-raise dm_req each IDLE cycle, STARVE_MAX=4 → exactly 4 DM grants, then IF granted. starve_cnt returns to 0.
- Timeout: grant DM and never assert mem_ready, TIMEOUT=15 → after 15 busy cycles: dm_ack=1, dm_rdata=0, bus_err=1 for one cycle, then IDLE. Repeat with mem_ready in cycle 15 → normal ack and bus_err=0.
- Masking/ignore: pulse mem_ready in IDLE → no ack. Requester holds req one cycle past ack → it is not re-granted in the ack cycle; the other pending requester is granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-ported memory between instruction fetch and data access.
// Data access has priority; IF is protected by a starvation counter and hung transactions time out.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        addr_sel,
    output logic        mem_valid,
    output logic        mem_we,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_LIM  = SW'(STARVE_MAX);
    localparam logic [WW-1:0] TIMEOUT_LIM = WW'(TIMEOUT);
    localparam logic [WW-1:0] WAIT_ONE    = WW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          addr_sel_q, addr_sel_d;
    logic          mem_valid_q, mem_valid_d;
    logic          mem_we_q, mem_we_d;
    logic          if_ack_q, if_ack_d;
    logic          dm_ack_q, dm_ack_d;
    logic          bus_err_q, bus_err_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;

    logic          if_req_m, dm_req_m;
    logic          xfer_done;
    logic [31:0]   xfer_data;

    // A requester still showing its ack this cycle cannot be re-granted yet.
    assign if_req_m  = if_req & ~if_ack_q;
    assign dm_req_m  = dm_req & ~dm_ack_q;
    assign xfer_done = mem_ready | (wait_q == TIMEOUT_LIM);
    assign xfer_data = mem_ready ? mem_rdata : '0;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        addr_sel_d  = addr_sel_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        bus_err_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (dm_req_m && (!if_req_m || (starve_q < STARVE_LIM))) begin
                    state_d     = DM_BUSY;
                    addr_sel_d  = 1'b1;
                    mem_we_d    = dm_we;
                    mem_valid_d = 1'b1;
                    wait_d      = WAIT_ONE;
                    if (if_req_m) begin
                        starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
                    end else begin
                        starve_d = '0;
                    end
                end else if (if_req_m) begin
                    state_d     = IF_BUSY;
                    addr_sel_d  = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_valid_d = 1'b1;
                    wait_d      = WAIT_ONE;
                    starve_d    = '0;
                end
            end

            IF_BUSY, DM_BUSY: begin
                if (xfer_done) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    mem_we_d    = 1'b0;
                    wait_d      = '0;
                    bus_err_d   = ~mem_ready;
                    if (state_q == IF_BUSY) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = xfer_data;
                    end else begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = xfer_data;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            wait_q      <= '0;
            addr_sel_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            addr_sel_q  <= addr_sel_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            bus_err_q   <= bus_err_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign addr_sel  = addr_sel_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign bus_err   = bus_err_q;

endmodule
